cascade_idelay_calib: RTL and testbench
=======================================

Name: cascade_idelay_calib

Overview:
- Training controller that drives the per-lane IDELAYE2 tap controls of the cascade PHY input path.
- One calibration sweeps all 32 taps on every lane in parallel. At each tap it compares the delayed receive bit with the expected training bit.
- Per lane, it finds the widest contiguous passing window and loads the window centre as the final tap.
- It sits between the link-training sequencer and the cascade IOB block, and feeds that block's delay ce/inc/ld/val inputs.

Parameters:
- LANES, 3, number of delayed input lanes (DAT_IN+CMD_IN); lane order is cmd lanes first, then dat lanes.
- SETTLE_CYC, 16, cycles waited after a tap load before sampling starts (≥1).
- SAMPLE_CYC, 64, compare cycles per tap (≥1).
- MIN_WIN, 4, minimum passing-window length in taps for a lane to count as calibrated (1..32).
- DEFAULT_TAP, 1, tap loaded on a lane that fails calibration (0..31).

Ports:
- i_clk  in  1  delay-control clock (same as IDELAYE2 C).
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  start calibration; sampled only in IDLE.
- i_rx  in  LANES  delayed receive bits (IDELAY DATAOUT), already in the i_clk domain.
- i_exp  in  LANES  expected training bits, cycle-aligned to i_rx.
- o_delay_ce  out  LANES  constant 0.
- o_delay_inc  out  LANES  constant 0.
- o_delay_ld  out  LANES  tap load strobe, all bits identical.
- o_delay_val  out  LANES*5  per-lane tap value; lane k uses bits [k*5+4:k*5].
- o_busy  out  1  calibration in progress.
- o_done  out  1  one-cycle completion pulse.
- o_fail  out  LANES  per-lane failure flag, valid from o_done until the next start.
- o_win_len  out  LANES*6  per-lane best window length (0..32), same validity as o_fail.

Behaviour:
- Reset: state IDLE. o_delay_ld=0, o_delay_val=0, o_busy=0, o_done=0, o_fail=0, o_win_len=0. All per-lane trackers and the tap counter clear.
- Reset mid-sweep: abort immediately to the reset state. No final load is issued.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, EVAL, FINAL_LD, DONE.
- IDLE: when i_start=1, clear trackers, set tap=0, clear o_fail/o_win_len, go to LOAD.
  - i_start is ignored in every other state.
- LOAD (1 cycle): o_delay_ld=all ones; o_delay_val=tap on every lane. Go to SETTLE.
  - o_delay_val holds its value until the next load.
- SETTLE: lasts SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: lasts SAMPLE_CYC cycles. Per lane, err[k] is set if i_rx[k]!=i_exp[k] in any cycle. err clears on entry to SAMPLE.
- EVAL (1 cycle), per lane:
  - Pass (err=0): if run_len==0 then run_start=tap; run_len+=1. If the new run_len > best_len, then best_start=run_start and best_len=run_len.
  - Fail: run_len=0.
  - The strict > comparison means the earliest window wins a tie.
  - If tap==31 go to FINAL_LD, else tap+=1 and go to LOAD.
- FINAL_LD (1 cycle): o_delay_ld=all ones.
  - Per lane, o_delay_val = best_start + ((best_len-1)>>1) when best_len ≥ MIN_WIN. Otherwise o_delay_val=DEFAULT_TAP and o_fail[k]=1.
  - o_win_len[k]=best_len.
- DONE (1 cycle): o_done=1, then go to IDLE.
- o_busy=1 in LOAD through FINAL_LD; 0 in IDLE and DONE.
- Width: run_len and best_len are 6 bits, since the full 32-tap window must be representable. Centre arithmetic is done in 6 bits and truncated to 5 bits; the result is always ≤31.
- Latency: with i_start sampled high in cycle 0, the first LOAD is in cycle 1. Each tap takes SETTLE_CYC+SAMPLE_CYC+2 cycles. FINAL_LD is in cycle 32*(SETTLE_CYC+SAMPLE_CYC+2)+1 and o_done is in the next cycle. With defaults, o_done is in cycle 2626.
- A window still open at tap 31 is closed correctly, because best is updated on every passing EVAL.

Test Plan:
- Defaults; lane 0 passes only taps 10..19, lanes 1..2 pass 0..31 -> o_done in cycle 2626; vals 14/15/15; o_win_len 10/32/32; o_fail=0; exactly 33 ld pulses.
- Lane 0 passes 3..6 and 20..27 -> best window 20..27, o_delay_val lane0 = 23, o_win_len=8.
- Lane 0 passes 2..5 and 12..15 (tie) -> first window kept, val=3, o_win_len=4.
- Lane 1 passes only 8..10 (len 3 < MIN_WIN) -> o_fail[1]=1, lane1 final val=DEFAULT_TAP=1, o_win_len=3; other lanes unaffected.
- Single mismatch injected in the last SAMPLE cycle at tap 16, lane 2 otherwise all-pass -> windows 0..15 and 17..31; best is 0..15 (len 16 > 15), val=7.
- i_start pulsed during SAMPLE -> ignored, timing unchanged. i_rst asserted at tap 7 -> next cycle all outputs 0 and state IDLE. A new i_start then completes normally in 2626 cycles.

Source files
------------

// File: rtl/cascade_idelay_calib.sv
// IDELAYE2 tap training controller: sweeps all 32 taps on every lane, tracks the widest
// passing window per lane and loads its centre (or a fallback tap) when the sweep ends.
module cascade_idelay_calib #(
  parameter int unsigned LANES       = 3,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned SAMPLE_CYC  = 64,
  parameter int unsigned MIN_WIN     = 4,
  parameter int unsigned DEFAULT_TAP = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [LANES-1:0]   i_rx,
  input  logic [LANES-1:0]   i_exp,
  output logic [LANES-1:0]   o_delay_ce,
  output logic [LANES-1:0]   o_delay_inc,
  output logic [LANES-1:0]   o_delay_ld,
  output logic [LANES*5-1:0] o_delay_val,
  output logic               o_busy,
  output logic               o_done,
  output logic [LANES-1:0]   o_fail,
  output logic [LANES*6-1:0] o_win_len
);

  localparam int unsigned MaxCyc = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SAMPLE_CYC - 1);
  localparam logic [5:0]      MinWin     = 6'(MIN_WIN);
  localparam logic [4:0]      DefTap     = 5'(DEFAULT_TAP);

  typedef enum logic [2:0] {
    StIdle, StLoad, StSettle, StSample, StEval, StFinalLd, StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [4:0]                tap_q, tap_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [LANES-1:0]          err_q, err_d;
  logic [LANES-1:0][5:0]     run_len_q, run_len_d, best_len_q, best_len_d;
  logic [LANES-1:0][4:0]     run_start_q, run_start_d, best_start_q, best_start_d;
  logic [LANES*5-1:0]        val_q, val_d;
  logic [LANES-1:0]          fail_q, fail_d;
  logic [LANES*6-1:0]        win_len_q, win_len_d;

  logic                      ld;
  logic [LANES-1:0][5:0]     centre;
  logic [LANES-1:0]          win_ok;
  logic [LANES*5-1:0]        final_val;

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      // Centre in 6 bits so a full 32-tap window (len 32) cannot wrap before truncation.
      centre[k]         = {1'b0, best_start_q[k]} + ((best_len_q[k] - 6'd1) >> 1);
      win_ok[k]         = best_len_q[k] >= MinWin;
      final_val[k*5+:5] = win_ok[k] ? centre[k][4:0] : DefTap;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    val_d        = val_q;
    fail_d       = fail_q;
    win_len_d    = win_len_q;
    ld           = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          run_len_d    = '0;
          run_start_d  = '0;
          best_len_d   = '0;
          best_start_d = '0;
          err_d        = '0;
          tap_d        = 5'd0;
          fail_d       = '0;
          win_len_d    = '0;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        o_busy  = 1'b1;
        ld      = 1'b1;
        val_d   = {LANES{tap_q}};
        cnt_d   = '0;
        state_d = StSettle;
      end
      StSettle: begin
        o_busy = 1'b1;
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        o_busy = 1'b1;
        err_d  = ((cnt_q == '0) ? '0 : err_q) | (i_rx ^ i_exp);
        if (cnt_q == SampleLast) begin
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StEval: begin
        o_busy = 1'b1;
        for (int unsigned k = 0; k < LANES; k++) begin
          if (!err_q[k]) begin
            if (run_len_q[k] == 6'd0) run_start_d[k] = tap_q;
            run_len_d[k] = run_len_q[k] + 6'd1;
            // Strict compare: an equal-length later window never displaces the earlier one.
            if (run_len_d[k] > best_len_q[k]) begin
              best_start_d[k] = run_start_d[k];
              best_len_d[k]   = run_len_d[k];
            end
          end else begin
            run_len_d[k] = 6'd0;
          end
        end
        if (tap_q == 5'd31) begin
          state_d = StFinalLd;
        end else begin
          tap_d   = tap_q + 5'd1;
          state_d = StLoad;
        end
      end
      StFinalLd: begin
        o_busy  = 1'b1;
        ld      = 1'b1;
        val_d   = final_val;
        fail_d  = ~win_ok;
        for (int unsigned k = 0; k < LANES; k++) win_len_d[k*6+:6] = best_len_q[k];
        state_d = StDone;
      end
      StDone: begin
        o_done  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      tap_q        <= 5'd0;
      cnt_q        <= '0;
      err_q        <= '0;
      run_len_q    <= '0;
      run_start_q  <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
      val_q        <= '0;
      fail_q       <= '0;
      win_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      val_q        <= val_d;
      fail_q       <= fail_d;
      win_len_q    <= win_len_d;
    end
  end

  // The tap value is visible in the same cycle as its load strobe.
  assign o_delay_val = (state_q == StLoad)    ? {LANES{tap_q}} :
                       (state_q == StFinalLd) ? final_val      : val_q;
  assign o_delay_ld  = {LANES{ld}};
  assign o_delay_ce  = '0;
  assign o_delay_inc = '0;
  assign o_fail      = fail_q;
  assign o_win_len   = win_len_q;

endmodule

// File: tb/tb_cascade_idelay_calib.sv
// Directed vector bench for cascade_idelay_calib: per-lane pass masks over the 32 taps
// with hand-computed final taps, window lengths, fail flags and completion timing.
module tb_cascade_idelay_calib;

  localparam int Lanes = 3;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_start;
  logic [Lanes-1:0]   i_rx;
  logic [Lanes-1:0]   i_exp;
  logic [Lanes-1:0]   o_delay_ce;
  logic [Lanes-1:0]   o_delay_inc;
  logic [Lanes-1:0]   o_delay_ld;
  logic [Lanes*5-1:0] o_delay_val;
  logic               o_busy;
  logic               o_done;
  logic [Lanes-1:0]   o_fail;
  logic [Lanes*6-1:0] o_win_len;

  cascade_idelay_calib dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_rx        (i_rx),
    .i_exp       (i_exp),
    .o_delay_ce  (o_delay_ce),
    .o_delay_inc (o_delay_inc),
    .o_delay_ld  (o_delay_ld),
    .o_delay_val (o_delay_val),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_win_len   (o_win_len)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0][31:0] pass;
    int               inj_tap;
    int               inj_lane;
    int               glitch_cyc;
    logic [2:0][4:0]  exp_val;
    logic [2:0][5:0]  exp_win;
    logic [2:0]       exp_fail;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input int inj_tap, input int inj_lane,
                              input int glitch, input int v0, input int v1, input int v2,
                              input int w0, input int w1, input int w2, input logic [2:0] f);
    vec_t v;
    v.pass[0] = p0;  v.pass[1] = p1;  v.pass[2] = p2;
    v.inj_tap = inj_tap;  v.inj_lane = inj_lane;  v.glitch_cyc = glitch;
    v.exp_val[0] = 5'(v0);  v.exp_val[1] = 5'(v1);  v.exp_val[2] = 5'(v2);
    v.exp_win[0] = 6'(w0);  v.exp_win[1] = 6'(w1);  v.exp_win[2] = 6'(w2);
    v.exp_fail = f;
    return v;
  endfunction

  // Acts as the delayed-line model: outside the sample window inputs are random garbage,
  // inside it a lane mismatches on every cycle of a failing tap.
  task automatic run_cal(input vec_t v, input int abort_tap, output int done_cyc,
                         output int ld_cnt, output int seq_err, output logic [14:0] fin_val,
                         output logic [2:0] fin_fail, output logic [17:0] fin_win);
    int cyc, tap, since;
    bit rst_pend;
    logic e, r;
    done_cyc = -1; ld_cnt = 0; seq_err = 0; fin_val = '0; fin_fail = '1; fin_win = '1;
    tap = 0; since = 1000; rst_pend = 0; cyc = 0;
    i_start = 1'b1;
    i_rx = 3'($urandom); i_exp = 3'($urandom);
    while (cyc < 4000) begin
      @(posedge i_clk); #1;
      cyc++;
      i_start = (cyc == v.glitch_cyc);
      if (rst_pend) begin
        i_rst = 1'b0;
        check("abort_ld", int'(o_delay_ld), 0);
        check("abort_val", int'(o_delay_val), 0);
        check("abort_busy", int'(o_busy), 0);
        check("abort_done", int'(o_done), 0);
        check("abort_fail", int'(o_fail), 0);
        check("abort_win", int'(o_win_len), 0);
        return;
      end
      if (o_delay_ld[0]) begin
        if (ld_cnt < 32 && int'(o_delay_val[4:0]) != ld_cnt) seq_err++;
        if (o_delay_ld != 3'b111) seq_err++;
        ld_cnt++;
        tap = int'(o_delay_val[4:0]);
        since = 0;
        fin_val = o_delay_val;
      end else begin
        since++;
      end
      for (int l = 0; l < Lanes; l++) begin
        e = 1'($urandom);
        if (since >= 17 && since <= 80) begin
          r = e ^ ~v.pass[l][tap];
          if (tap == v.inj_tap && l == v.inj_lane && since == 80) r = ~e;
        end else begin
          r = 1'($urandom);
        end
        i_exp[l] = e;
        i_rx[l]  = r;
      end
      if (abort_tap == tap && since == 40 && ld_cnt <= 32) begin
        i_rst = 1'b1;
        rst_pend = 1;
      end
      if (o_done) begin
        done_cyc = cyc;
        fin_fail = o_fail;
        fin_win  = o_win_len;
        break;
      end
    end
  endtask

  task automatic run_and_check(input vec_t v, input int idx);
    int done_cyc, ld_cnt, seq_err;
    logic [14:0] fv;
    logic [2:0] ff;
    logic [17:0] fw;
    run_cal(v, -1, done_cyc, ld_cnt, seq_err, fv, ff, fw);
    check($sformatf("v%0d_done_cyc", idx), done_cyc, 2626);
    check($sformatf("v%0d_ld_cnt", idx), ld_cnt, 33);
    check($sformatf("v%0d_tap_seq_err", idx), seq_err, 0);
    check($sformatf("v%0d_busy_at_done", idx), int'(o_busy), 0);
    check($sformatf("v%0d_fail", idx), int'(ff), int'(v.exp_fail));
    for (int l = 0; l < Lanes; l++) begin
      check($sformatf("v%0d_val_lane%0d", idx, l), int'(fv[l*5+:5]), int'(v.exp_val[l]));
      check($sformatf("v%0d_win_lane%0d", idx, l), int'(fw[l*6+:6]), int'(v.exp_win[l]));
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    vec_t vecs[5];
    vec_t all_pass;
    int done_cyc, ld_cnt, seq_err;
    logic [14:0] fv;
    logic [2:0] ff;
    logic [17:0] fw;

    vecs[0] = mk(32'h000F_FC00, '1, '1, -1, 0, -1, 14, 15, 15, 10, 32, 32, 3'b000);
    vecs[1] = mk(32'h0FF0_0078, '1, '1, -1, 0, -1, 23, 15, 15, 8, 32, 32, 3'b000);
    vecs[2] = mk(32'h0000_F03C, '1, '1, -1, 0, -1, 3, 15, 15, 4, 32, 32, 3'b000);
    vecs[3] = mk('1, 32'h0000_0700, '1, -1, 0, -1, 15, 1, 15, 32, 3, 32, 3'b010);
    vecs[4] = mk('1, '1, '1, 16, 2, 30, 15, 15, 7, 32, 32, 16, 3'b000);
    all_pass = mk('1, '1, '1, -1, 0, -1, 15, 15, 15, 32, 32, 32, 3'b000);

    i_rst = 1'b1; i_start = 1'b0; i_rx = '0; i_exp = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ld", int'(o_delay_ld), 0);
    check("rst_val", int'(o_delay_val), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_fail", int'(o_fail), 0);
    check("rst_win", int'(o_win_len), 0);
    check("ce_const", int'(o_delay_ce), 0);
    check("inc_const", int'(o_delay_inc), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("idle_busy", int'(o_busy), 0);

    for (int i = 0; i < 5; i++) run_and_check(vecs[i], i);

    // Abort during tap 7, then a fresh calibration must run its full length.
    run_cal(all_pass, 7, done_cyc, ld_cnt, seq_err, fv, ff, fw);
    check("abort_ld_cnt", ld_cnt, 8);
    check("abort_no_done", done_cyc, -1);
    @(posedge i_clk); #1;
    check("abort_idle_busy", int'(o_busy), 0);
    run_and_check(all_pass, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
